parser_rule_loader: RTL

- Configuration master for the parser's rule-write bus (wren/rden/addr/wdata/rdata_valid/rdata), i.e. the initiator side of the conf port on Parser_Top.
- A host pushes (addr, wdata, verify) entries into an internal table, then pulses start.
- The loader replays the table as single-cycle rule writes, optionally reads each entry back and compares it, and reports done or error with the failing entry index.

---
 rtl/parser_rule_loader_if.sv | 20 ++
 rtl/parser_rule_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/parser_rule_loader_if.sv
// Rule-write bus between the rule loader and the parser conf port.
// Master issues write/read strobes, slave answers reads.
interface parser_rule_loader_if;
  logic        wren;
  logic        rden;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;

  modport master (
    output wren, rden, addr, wdata,
    input  rdata_valid, rdata
  );

  modport slave (
    input  wren, rden, addr, wdata,
    output rdata_valid, rdata
  );
endinterface

// File: rtl/parser_rule_loader.sv
// Rule table loader: host fills a command table, then the
// loader replays it on the rule bus with optional readback.
module parser_rule_loader #(
  parameter int DEPTH      = 32,
  parameter int RD_TIMEOUT = 16,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [31:0]      i_cmd_addr,
  input  logic [31:0]      i_cmd_wdata,
  input  logic             i_cmd_verify,
  input  logic             i_clear,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [1:0]       o_err_code,
  output logic [IDX_W-1:0] o_err_index,
  output logic [IDX_W:0]   o_count,
  parser_rule_loader_if.master rule
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [IDX_W:0] FULL =
    (IDX_W+1)'(DEPTH);
  localparam logic [TW-1:0] TLAST =
    TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, WRITE, READ_REQ,
    READ_WAIT, NEXT, DONE, ERR
  } state_t;

  state_t state, nxt;

  logic [31:0]      t_addr  [DEPTH];
  logic [31:0]      t_wdata [DEPTH];
  logic [DEPTH-1:0] t_ver;

  logic [IDX_W:0]   count;
  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] ptr;
  logic [TW-1:0]    tmr;
  logic             rdy_en;
  logic [1:0]       code;
  logic             idle;
  logic             push;
  logic             strobe;
  logic [31:0]      e_addr;
  logic [31:0]      e_wdata;
  logic             e_ver;

  assign idle    = (state == IDLE);
  assign ptr     = idx[IDX_W-1:0];
  assign e_addr  = t_addr[ptr];
  assign e_wdata = t_wdata[ptr];
  assign e_ver   = t_ver[ptr];

  assign o_cmd_ready = rdy_en & idle & (count != FULL);
  assign push = i_cmd_valid & o_cmd_ready & ~i_clear;
  assign o_count = count;

  // table storage, written only by accepted pushes
  always_ff @(posedge clk) begin
    if (push) begin
      t_addr[count[IDX_W-1:0]]  <= i_cmd_addr;
      t_wdata[count[IDX_W-1:0]] <= i_cmd_wdata;
      t_ver[count[IDX_W-1:0]]   <= i_cmd_verify;
    end
  end

  // replay sequencing: next state and error code
  always_comb begin
    nxt  = state;
    code = 2'd0;
    unique case (state)
      IDLE: if (i_start) nxt = CHECK;
      CHECK: begin
        if (idx == count) begin
          nxt = DONE;
        end else if (e_addr[10:8] > 3'd5) begin
          nxt  = ERR;
          code = 2'd3;
        end else begin
          nxt = WRITE;
        end
      end
      WRITE: nxt = e_ver ? READ_REQ : NEXT;
      READ_REQ: nxt = READ_WAIT;
      READ_WAIT: begin
        if (rule.rdata_valid) begin
          if (rule.rdata == e_wdata) begin
            nxt = NEXT;
          end else begin
            nxt  = ERR;
            code = 2'd1;
          end
        end else if (tmr == TLAST) begin
          nxt  = ERR;
          code = 2'd2;
        end
      end
      NEXT: nxt = CHECK;
      DONE: nxt = IDLE;
      ERR: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state, counters and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      idx         <= '0;
      tmr         <= '0;
      rdy_en      <= 1'b0;
      o_error     <= 1'b0;
      o_err_code  <= 2'd0;
      o_err_index <= '0;
    end else begin
      state  <= nxt;
      rdy_en <= 1'b1;
      if (idle && i_clear) count <= '0;
      else if (push) count <= count + 1'b1;
      if (idle && i_start) idx <= '0;
      else if (state == NEXT) idx <= idx + 1'b1;
      if (state == READ_REQ) tmr <= '0;
      else if (state == READ_WAIT) tmr <= tmr + 1'b1;
      if (idle && i_start) begin
        o_error     <= 1'b0;
        o_err_code  <= 2'd0;
        o_err_index <= '0;
      end else if (nxt == ERR) begin
        o_error     <= 1'b1;
        o_err_code  <= code;
        o_err_index <= ptr;
      end
    end
  end

  // bus outputs decoded from state, zero when idle
  always_comb begin
    rule.wren  = (state == WRITE);
    rule.rden  = (state == READ_REQ);
    strobe     = rule.wren | rule.rden;
    rule.addr  = strobe ? e_addr : 32'd0;
    rule.wdata = strobe ? e_wdata : 32'd0;
    o_busy = (state == CHECK) || (state == WRITE) ||
             (state == READ_REQ) ||
             (state == READ_WAIT) || (state == NEXT);
    o_done = (state == DONE);
  end
endmodule
